mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit for the pipelined MIPS datapath; executes mult, multu, div, divu, mthi and mtlo issued from the EX stage and holds the HI/LO architectural registers. It sits beside the single-cycle ALU. The ALU returns its result in the same cycle. This unit accepts an operation, asserts `busy` for a fixed latency, then commits HI/LO; hazard logic stalls on `busy` and on any `start` in flight.

---
 rtl/md_pkg.sv | 23 ++
 rtl/mult_div_unit_if.sv | 20 ++
 rtl/mult_div_unit.sv | 139 +++++++++++++
 tb/tb_mult_div_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - MDOp encodings driven by the control decoder (MD_NONE .. MD_MTLO).
//   - Default latencies for multiply and divide operations.
//   - State type for the unit's IDLE/RUN controller.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/result bundle between the EX stage and the
// multiply/divide unit.
//   start  - operation strobe from EX
//   MDOp   - operation code (md_pkg encodings)
//   A, B   - rs / rt operands
//   busy   - unit is executing a multi-cycle operation
//   HI, LO - architectural HI/LO registers
// master: issuing side (pipeline). slave: the unit itself.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDOp, A, B, input busy, HI, LO);
  modport slave  (input start, MDOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding HI/LO.
// The full result is computed combinationally at issue and parked in
// hi_tmp/lo_tmp; a down-counter models the architectural latency, after
// which the result is committed to HI/LO and busy drops.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset
//   md    - slave side of mult_div_unit_if (start/MDOp/A/B in,
//           busy/HI/LO out; all outputs are registered)
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_tmp_q, hi_tmp_d;
  logic [31:0]      lo_tmp_q, lo_tmp_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] b_sdiv, b_udiv;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        div_zero, div_ovf;
  logic [63:0] res;

  // Arithmetic datapath. The divisors are forced to 1 in the divide-by-zero
  // and INT_MIN / -1 cases so the operators never see an undefined input;
  // those cases are then resolved explicitly in the result mux.
  always_comb begin
    div_zero = (md.B == 32'd0);
    div_ovf  = (md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF);
    b_sdiv   = (div_zero || div_ovf) ? 32'd1 : md.B;
    b_udiv   = div_zero ? 32'd1 : md.B;

    prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    prod_u = {32'd0, md.A} * {32'd0, md.B};
    q_s    = $signed(md.A) / $signed(b_sdiv);
    r_s    = $signed(md.A) % $signed(b_sdiv);
    q_u    = md.A / b_udiv;
    r_u    = md.A % b_udiv;

    // Divide by zero parks the current HI/LO so the commit is a no-op.
    res = {hi_q, lo_q};
    case (md.MDOp)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (div_zero)     res = {hi_q, lo_q};
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {r_s, q_s};
      end
      MD_DIVU:  res = div_zero ? {hi_q, lo_q} : {r_u, q_u};
      default:  res = {hi_q, lo_q};
    endcase
  end

  // Controller: accepts work only in IDLE, counts down in RUN and commits
  // the parked result on the edge where the counter is at 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;

    case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md.MDOp)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              hi_tmp_d = res[63:32];
              lo_tmp_d = res[31:0];
              cnt_d    = (md.MDOp == MD_DIV || md.MDOp == MD_DIVU) ?
                         CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_d  = RUN;
              busy_d   = 1'b1;
            end
            MD_MTHI: hi_d = md.A;
            MD_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  assign md.busy = busy_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit.
// A directed vector table covers the documented arithmetic cases, a few
// hand-written sequences cover reset/ignored-start corners, and random
// operations are compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  vec_t vecs[11];

  mult_div_unit_if bus();

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural effect of one operation on HI/LO,
  // computed with 64-bit arithmetic (so INT_MIN / -1 needs no special case).
  function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = {hi, lo};
    case (op)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = ua * ub;
      OP_DIV: begin
        if (b != 32'd0) begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: if (b != 32'd0) p = {32'(ua % ub), 32'(ua / ub)};
      OP_MTHI:  p = {a, lo};
      OP_MTLO:  p = {hi, a};
      default:  p = {hi, lo};
    endcase
    return p;
  endfunction

  function automatic int refLatency(input logic [2:0] op);
    if (op == OP_MULT || op == OP_MULTU) return MULT_N;
    if (op == OP_DIV || op == OP_DIVU) return DIV_N;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for exactly one clock edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    bus.MDOp  = OP_NONE;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one operation, measures the busy window (bounded), checks that
  // HI/LO hold their old values while busy, then checks the committed result.
  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int exp_n, input logic [31:0] old_hi, input logic [31:0] old_lo);
    int   n;
    logic stable;
    n      = 0;
    stable = 1'b1;
    applyStimulus(op, a, b);
    while (bus.busy && n < 100) begin
      if (bus.HI !== old_hi || bus.LO !== old_lo) stable = 1'b0;
      n++;
      tick();
    end
    checkOutput({name, " busy_cycles"}, 32'(n), 32'(exp_n));
    if (exp_n > 0) checkOutput({name, " hold_while_busy"}, {31'd0, stable}, 32'd1);
    checkOutput({name, " HI"}, bus.HI, exp_hi);
    checkOutput({name, " LO"}, bus.LO, exp_lo);
    checkOutput({name, " busy_after"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          n;
    logic        saw_busy;

    checks = 0;
    errors = 0;

    vecs[0]  = '{OP_MULT,  32'd3,          32'd4,          32'h0000_0000, 32'h0000_000C, MULT_N};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_N};
    vecs[2]  = '{OP_MULTU, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 32'hFFFF_FFFE, MULT_N};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vecs[4]  = '{OP_DIVU,  32'd7,          32'd2,          32'h0000_0001, 32'h0000_0003, DIV_N};
    vecs[5]  = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, DIV_N};
    vecs[6]  = '{OP_MTHI,  32'h11,         32'd0,          32'h0000_0011, 32'h8000_0000, 0};
    vecs[7]  = '{OP_MTLO,  32'h22,         32'd0,          32'h0000_0011, 32'h0000_0022, 0};
    vecs[8]  = '{OP_DIVU,  32'd5,          32'd0,          32'h0000_0011, 32'h0000_0022, DIV_N};
    vecs[9]  = '{OP_MTHI,  32'h1234,       32'd0,          32'h0000_1234, 32'h0000_0022, 0};
    vecs[10] = '{OP_MTLO,  32'h5678,       32'd0,          32'h0000_1234, 32'h0000_5678, 0};

    // Reset held while an operation is being strobed.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.MDOp  = OP_MULT;
    bus.A     = 32'd3;
    bus.B     = 32'd4;
    repeat (3) tick();
    checkOutput("reset HI", bus.HI, 32'd0);
    checkOutput("reset LO", bus.LO, 32'd0);
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.MDOp  = OP_NONE;
    tick();
    checkOutput("post_reset busy", {31'd0, bus.busy}, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;

    // Directed vectors; vecs[9]/vecs[10] land on consecutive edges.
    for (int i = 0; i < 11; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, vecs[i].n, hi_m, lo_m);
      hi_m = vecs[i].hi;
      lo_m = vecs[i].lo;
    end

    // An mtlo strobed during RUN must be ignored.
    applyStimulus(OP_MULT, 32'd5, 32'd7);
    n = 1;
    tick();
    n++;
    applyStimulus(OP_MTLO, 32'hDEAD, 32'd0);
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    checkOutput("ignored_start busy_cycles", 32'(n), 32'(MULT_N));
    checkOutput("ignored_start HI", bus.HI, 32'd0);
    checkOutput("ignored_start LO", bus.LO, 32'd35);
    hi_m = 32'd0;
    lo_m = 32'd35;

    // Reset in cycle 3 of a divide aborts it with no later commit.
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort HI", bus.HI, 32'd0);
    checkOutput("abort LO", bus.LO, 32'd0);
    saw_busy = 1'b0;
    for (int i = 0; i < DIV_N + 4; i++) begin
      if (bus.busy) saw_busy = 1'b1;
      tick();
    end
    checkOutput("abort no_busy", {31'd0, saw_busy}, 32'd0);
    checkOutput("abort no_commit HI", bus.HI, 32'd0);
    checkOutput("abort no_commit LO", bus.LO, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      exp = refModel(op, a, b, hi_m, lo_m);
      runOp($sformatf("rand%0d op%0d", i, op), op, a, b, exp[63:32], exp[31:0],
            refLatency(op), hi_m, lo_m);
      hi_m = exp[63:32];
      lo_m = exp[31:0];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
